// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory initiator: size codes,
// FSM states and the request fault check.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        RMW_WRITE = 2'b10,
        DONE      = 2'b11
    } state_t;

    // Misalignment, reserved size, or a word index beyond the memory.
    function automatic logic addr_fault(input logic [1:0] size,
                                        input logic [31:0] addr,
                                        input int unsigned mem_words);
        logic w_bad_align;
        case (size)
            SZ_BYTE: w_bad_align = 1'b0;
            SZ_HALF: w_bad_align = addr[0];
            SZ_WORD: w_bad_align = (addr[1:0] != 2'b00);
            default: w_bad_align = 1'b1;
        endcase
        return w_bad_align || ({2'b00, addr[31:2]} >= mem_words);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends load data, and merges
// sub-word store data into the word read back from memory.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_rdata,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        o_load_data  = i_rdata;
        o_store_word = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
                o_store_word[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load_data = {{16{i_signed & w_half[15]}}, w_half};
                o_store_word[{i_offset[1], 4'b0000} +: 16] = i_wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: turns byte-addressed loads/stores into word-indexed
// memory accesses, with read-modify-write for sub-word stores.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        fault,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Addr,
    output logic [31:0] Wdata,
    input  logic [31:0] Rdata
);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [15:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_fault;

    logic        w_fault;
    logic        w_idle_go;
    logic        w_word_store;
    logic [31:0] w_load_data;
    logic [31:0] w_store_word;

    assign w_fault      = addr_fault(req_size, req_addr, MEM_WORDS);
    assign w_idle_go    = !rst && (r_state == IDLE) && req_valid && !w_fault;
    assign w_word_store = req_write && (req_size == SZ_WORD);

    assign MemRead  = w_idle_go && !w_word_store;
    assign MemWrite = (w_idle_go && w_word_store) || (!rst && (r_state == RMW_WRITE));
    assign stall    = !rst && ((r_state == IDLE) ? req_valid
                               : (r_state == LOAD_WAIT || r_state == RMW_WRITE));
    assign Addr     = (r_state == IDLE) ? {2'b00, req_addr[31:2]} : {2'b00, r_addr[31:2]};
    assign Wdata    = (r_state == RMW_WRITE) ? w_store_word : req_wdata;

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign fault      = r_fault;

    mem_lane_align u_align (
        .i_offset     (r_addr[1:0]),
        .i_size       (r_size),
        .i_signed     (r_signed),
        .i_rdata      (Rdata),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    // NOTE: request copies are plain datapath registers; they are only read after an accept, so they need no reset.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && req_valid) begin
            r_addr   <= req_addr;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_wdata  <= req_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_resp_valid <= 1'b0;
                    r_fault      <= 1'b0;
                    if (req_valid) begin
                        if (w_fault || w_word_store) begin
                            r_state      <= DONE;
                            r_resp_valid <= 1'b1;
                            r_fault      <= w_fault;
                            r_resp_rdata <= '0;
                        end else if (!req_write) begin
                            r_state <= LOAD_WAIT;
                        end else begin
                            r_state <= RMW_WRITE;
                        end
                    end
                end
                LOAD_WAIT: begin
                    r_state      <= DONE;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                end
                RMW_WRITE: begin
                    r_state      <= DONE;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= '0;
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_fault      <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
